// File: rtl/ycbcr444_to_422.sv
// ycbcr444_to_422: converts a 4:4:4 Y/Cb/Cr stream into 4:2:2 Y plus multiplexed chroma.
// Fixed 2-cycle latency from the input register to the output register, syncs included.
// Optional macro CHROMA_AVG_EN: average chroma over each pixel pair
// (default: plain decimation, p1 chroma discarded).
module ycbcr444_to_422 #(
  parameter bit          CR_FIRST = 1'b0,
  parameter logic [7:0]  BLANK_Y  = 8'd16,
  parameter logic [7:0]  BLANK_C  = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_y_8b,
  input  logic [7:0] i_cb_8b,
  input  logic [7:0] i_cr_8b,
  input  logic       i_h_sync,
  input  logic       i_v_sync,
  input  logic       i_data_en,
  output logic [7:0] o_y_8b,
  output logic [7:0] o_c_8b,
  output logic       o_c_sel,
  output logic       o_h_sync,
  output logic       o_v_sync,
  output logic       o_data_en
);

  localparam int unsigned DW = 8;

`ifdef CHROMA_AVG_EN
  // Rounded mean of two samples; the 9-bit sum keeps the carry so the result fits 8 bits.
  function automatic logic [DW-1:0] avg8(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] sum;
    sum = (DW+1)'(a) + (DW+1)'(b) + (DW+1)'(1);
    return sum[DW:1];
  endfunction
`endif

  // Stage 1: input register plus the pixel's phase within its run
  logic [DW-1:0] s1_y_q, s1_cb_q, s1_cr_q, s1_y_d, s1_cb_d, s1_cr_d;
  logic          s1_hs_q, s1_vs_q, s1_de_q, s1_ph_q;
  logic          s1_hs_d, s1_vs_d, s1_de_d, s1_ph_d;
  // Stage 2: pixel whose output is being formed (its partner sits in stage 1)
  logic [DW-1:0] s2_y_q, s2_cb_q, s2_cr_q, s2_y_d, s2_cb_d, s2_cr_d;
  logic          s2_hs_q, s2_vs_q, s2_de_q, s2_ph_q;
  logic          s2_hs_d, s2_vs_d, s2_de_d, s2_ph_d;
  // Second chroma of the current pair, held from phase 0 to phase 1
  logic [DW-1:0] hold_q, hold_d;
  // Output register
  logic [DW-1:0] y_out_q, c_out_q, y_out_d, c_out_d;
  logic          sel_out_q, hs_out_q, vs_out_q, de_out_q;
  logic          sel_out_d, hs_out_d, vs_out_d, de_out_d;

  logic [DW-1:0] first_c, second_c;

  // Chroma for the phase-0 slot and the value held for the phase-1 slot
  always_comb begin
    first_c  = CR_FIRST ? s2_cr_q : s2_cb_q;
    second_c = CR_FIRST ? s2_cb_q : s2_cr_q;
`ifdef CHROMA_AVG_EN
    // Stage-1 data_en low means p0 is the last pixel of an odd run: keep its own chroma
    if (s1_de_q) begin
      first_c  = avg8(CR_FIRST ? s2_cr_q : s2_cb_q, CR_FIRST ? s1_cr_q : s1_cb_q);
      second_c = avg8(CR_FIRST ? s2_cb_q : s2_cr_q, CR_FIRST ? s1_cb_q : s1_cr_q);
    end
`endif
  end

  // Pipeline advance, phase tracking and output formatting
  always_comb begin
    s1_y_d    = i_y_8b;
    s1_cb_d   = i_cb_8b;
    s1_cr_d   = i_cr_8b;
    s1_hs_d   = i_h_sync;
    s1_vs_d   = i_v_sync;
    s1_de_d   = i_data_en;
    // Phase 0 on the first pixel of a run, toggling afterwards
    s1_ph_d   = i_data_en & s1_de_q & ~s1_ph_q;
    s2_y_d    = s1_y_q;
    s2_cb_d   = s1_cb_q;
    s2_cr_d   = s1_cr_q;
    s2_hs_d   = s1_hs_q;
    s2_vs_d   = s1_vs_q;
    s2_de_d   = s1_de_q;
    s2_ph_d   = s1_ph_q;
    hold_d    = hold_q;
    y_out_d   = BLANK_Y;
    c_out_d   = BLANK_C;
    sel_out_d = 1'b0;
    hs_out_d  = s2_hs_q;
    vs_out_d  = s2_vs_q;
    de_out_d  = s2_de_q;
    if (s2_de_q) begin
      y_out_d = s2_y_q;
      if (!s2_ph_q) begin
        c_out_d   = first_c;
        sel_out_d = CR_FIRST;
        hold_d    = second_c;
      end else begin
        c_out_d   = hold_q;
        sel_out_d = ~CR_FIRST;
      end
    end
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_y_q <= '0; s1_cb_q <= '0; s1_cr_q <= '0;
      s1_hs_q <= 1'b0; s1_vs_q <= 1'b0; s1_de_q <= 1'b0; s1_ph_q <= 1'b0;
      s2_y_q <= '0; s2_cb_q <= '0; s2_cr_q <= '0;
      s2_hs_q <= 1'b0; s2_vs_q <= 1'b0; s2_de_q <= 1'b0; s2_ph_q <= 1'b0;
      hold_q <= '0;
      y_out_q <= '0; c_out_q <= '0; sel_out_q <= 1'b0;
      hs_out_q <= 1'b0; vs_out_q <= 1'b0; de_out_q <= 1'b0;
    end else begin
      s1_y_q <= s1_y_d; s1_cb_q <= s1_cb_d; s1_cr_q <= s1_cr_d;
      s1_hs_q <= s1_hs_d; s1_vs_q <= s1_vs_d; s1_de_q <= s1_de_d; s1_ph_q <= s1_ph_d;
      s2_y_q <= s2_y_d; s2_cb_q <= s2_cb_d; s2_cr_q <= s2_cr_d;
      s2_hs_q <= s2_hs_d; s2_vs_q <= s2_vs_d; s2_de_q <= s2_de_d; s2_ph_q <= s2_ph_d;
      hold_q <= hold_d;
      y_out_q <= y_out_d; c_out_q <= c_out_d; sel_out_q <= sel_out_d;
      hs_out_q <= hs_out_d; vs_out_q <= vs_out_d; de_out_q <= de_out_d;
    end
  end

  assign o_y_8b    = y_out_q;
  assign o_c_8b    = c_out_q;
  assign o_c_sel   = sel_out_q;
  assign o_h_sync  = hs_out_q;
  assign o_v_sync  = vs_out_q;
  assign o_data_en = de_out_q;

endmodule
